// File: rtl/apb_mock_uart_mc.sv
// Multi-channel APB mock UART: per-channel TX FIFOs drained round-robin to a byte sink.
// Define MOCK_UART_DISPLAY_EN for simulation-only per-channel line printing of drained bytes.
module apb_mock_uart_mc #(
  parameter int unsigned NrChannels  = 4,
  parameter int unsigned FifoDepth   = 8,
  parameter int unsigned BaudDiv     = 16,
  parameter bit          BlockOnFull = 1'b1,
  parameter int unsigned AddrWidth   = 32,
  localparam int unsigned ChW        = (NrChannels > 1) ? $clog2(NrChannels) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [AddrWidth-1:0]  paddr_i,
  input  logic [31:0]           pwdata_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [ChW-1:0]        tx_chan_o,
  output logic [7:0]            tx_data_o,
  output logic [NrChannels-1:0] irq_o
);

  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_e;

  logic [7:0]            mem_q     [NrChannels][FifoDepth];
  logic [PtrW-1:0]       wptr_q    [NrChannels];
  logic [PtrW-1:0]       rptr_q    [NrChannels];
  logic [CntW-1:0]       cnt_q     [NrChannels];
  logic [31:0]           scratch_q [NrChannels];
  logic [NrChannels-1:0] ier_q, empty_c, full_c, push_vec_c, pop_vec_c;

  logic           access_c, chan_ok_c, complete_c, push_c, pop_c;
  logic           ready_c, err_c;
  logic [31:0]    rdata_c;
  logic [ChW-1:0] chan_c;
  logic [1:0]     offset_c;
  logic [8:0]     fill_c;
  logic [7:0]     fill_sat_c;
  logic           addr_unused;

  state_e         state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [ChW-1:0] rr_ptr_q, rr_ptr_d, pick_c, tx_chan_d;
  logic           any_c, tx_valid_d;
  logic [7:0]     head_c, tx_data_d;

  assign addr_unused = ^{paddr_i[AddrWidth-1:8], paddr_i[1:0]};
  assign access_c    = psel_i & penable_i;
  assign offset_c    = paddr_i[3:2];
  assign chan_ok_c   = 32'(paddr_i[7:4]) < NrChannels;
  assign chan_c      = ChW'(paddr_i[7:4]);

  always_comb begin
    for (int unsigned c = 0; c < NrChannels; c++) begin
      empty_c[c] = (cnt_q[c] == '0);
      full_c[c]  = (cnt_q[c] == CntW'(FifoDepth));
    end
  end

  assign fill_c     = 9'(cnt_q[chan_c]);
  assign fill_sat_c = (fill_c > 9'd255) ? 8'hFF : fill_c[7:0];

  // APB response; the full check uses the registered count, so a same-cycle pop does not unblock
  always_comb begin
    rdata_c = '0;
    ready_c = 1'b0;
    err_c   = 1'b0;
    if (access_c) begin
      ready_c = 1'b1;
      if (!chan_ok_c) begin
        err_c = 1'b1;
      end else begin
        unique case (offset_c)
          2'd0: if (pwrite_i && full_c[chan_c]) begin
                  if (BlockOnFull) ready_c = 1'b0;
                  else             err_c   = 1'b1;
                end
          2'd1: if (!pwrite_i) rdata_c = {16'h0, fill_sat_c, 2'b00, empty_c[chan_c], 3'b000,
                                          full_c[chan_c], empty_c[chan_c]};
          2'd2: if (!pwrite_i) rdata_c = {31'h0, ier_q[chan_c]};
          default: if (!pwrite_i) rdata_c = scratch_q[chan_c];
        endcase
      end
    end
  end

  assign prdata_o   = rdata_c;
  assign pready_o   = ready_c;
  assign pslverr_o  = err_c;
  assign complete_c = access_c & ready_c & ~err_c;
  assign push_c     = complete_c & pwrite_i & (offset_c == 2'd0);

  always_comb begin
    push_vec_c = '0;
    pop_vec_c  = '0;
    if (push_c) push_vec_c[chan_c]   = 1'b1;
    if (pop_c)  pop_vec_c[tx_chan_o] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ier_q <= '0;
      irq_o <= '0;
      for (int unsigned c = 0; c < NrChannels; c++) scratch_q[c] <= '0;
    end else begin
      irq_o <= ier_q & empty_c;
      if (complete_c && pwrite_i) begin
        if (offset_c == 2'd2) ier_q[chan_c]     <= pwdata_i[0];
        if (offset_c == 2'd3) scratch_q[chan_c] <= pwdata_i;
      end
    end
  end

  // FIFO pointers and fill counts; push and pop on one channel cancel in the count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < NrChannels; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NrChannels; c++) begin
        if (push_vec_c[c]) wptr_q[c] <= wptr_q[c] + PtrW'(1);
        if (pop_vec_c[c])  rptr_q[c] <= rptr_q[c] + PtrW'(1);
        if (push_vec_c[c] && !pop_vec_c[c])      cnt_q[c] <= cnt_q[c] + CntW'(1);
        else if (!push_vec_c[c] && pop_vec_c[c]) cnt_q[c] <= cnt_q[c] - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[chan_c][wptr_q[chan_c]] <= pwdata_i[7:0];
  end

  // Round-robin search starting one past the last served channel
  always_comb begin : rr_pick
    int unsigned idx;
    idx    = 0;
    any_c  = 1'b0;
    pick_c = '0;
    for (int unsigned i = 1; i <= NrChannels; i++) begin
      idx = (32'(rr_ptr_q) + i) % NrChannels;
      if (!any_c && !empty_c[ChW'(idx)]) begin
        any_c  = 1'b1;
        pick_c = ChW'(idx);
      end
    end
  end

  assign head_c = mem_q[pick_c][rptr_q[pick_c]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      rr_ptr_q   <= '0;
      tx_valid_o <= 1'b0;
      tx_chan_o  <= '0;
      tx_data_o  <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_valid_o <= tx_valid_d;
      tx_chan_o  <= tx_chan_d;
      tx_data_o  <= tx_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    rr_ptr_d   = rr_ptr_q;
    tx_valid_d = tx_valid_o;
    tx_chan_d  = tx_chan_o;
    tx_data_d  = tx_data_o;
    pop_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_c) begin
          state_d    = PRESENT;
          tx_valid_d = 1'b1;
          tx_chan_d  = pick_c;
          tx_data_d  = head_c;
        end
      end
      PRESENT: begin
        if (tx_ready_i) begin
          pop_c      = 1'b1;
          tx_valid_d = 1'b0;
          rr_ptr_d   = tx_chan_o;
          baud_d     = BaudW'(BaudDiv - 1);
          state_d    = (BaudDiv > 1) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (baud_q == '0) state_d = IDLE;
        else              baud_d  = baud_q - BaudW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MOCK_UART_DISPLAY_EN
  string line_buf [NrChannels];

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < NrChannels; c++) line_buf[c] = "";
    end else if (pop_c) begin
      if (tx_data_o == 8'h0A) begin
        $display("[uart%0d] %s", tx_chan_o, line_buf[tx_chan_o]);
        line_buf[tx_chan_o] = "";
      end else begin
        line_buf[tx_chan_o] = $sformatf("%s%c", line_buf[tx_chan_o], tx_data_o);
        if (line_buf[tx_chan_o].len() >= 128) begin
          $display("[uart%0d] %s", tx_chan_o, line_buf[tx_chan_o]);
          line_buf[tx_chan_o] = "";
        end
      end
    end
  end
`endif

endmodule
